coarse_interval_averager: RTL and testbench
===========================================

// Module: coarse_interval_averager
// PURPOSE
//   Downstream consumer of the coarse-counter interval result (16-bit start->stop count).
//   Accumulates a batch of 2**LOG2_N interval samples and reports the truncated mean,
//   minimum and maximum of the batch on a valid/ready output for readout logic.
//   Upstream has no backpressure; samples arriving while a result is pending are dropped
//   and flagged.
// PARAMETERS
//   DATA_W  16  width of interval samples and of mean/min/max outputs
//   LOG2_N  4   log2 of batch size (N = 16); legal range 1..8
// PORTS
//   clk        in   1       single clock; all logic on posedge clk
//   reset      in   1       synchronous, active-high reset
//   in_valid   in   1       one-cycle strobe: in_data holds a new interval result
//   in_data    in   DATA_W  interval count (0..60001 from coarse counter)
//   clear      in   1       synchronous batch/flag clear, same effect as reset
//   out_valid  out  1       batch result available; held until accepted
//   out_ready  in   1       consumer accepts result when out_valid & out_ready at posedge
//   out_mean   out  DATA_W  floor(sum of N samples / N)
//   out_min    out  DATA_W  smallest sample in batch
//   out_max    out  DATA_W  largest sample in batch
//   overrun    out  1       sticky: a sample was dropped while in HOLD
// BEHAVIOUR
//   Reset/clear: state=IDLE, acc=0, cnt=0, run_min=all-ones, run_max=0, out_valid=0,
//     out_mean=out_min=out_max=0, overrun=0. Priority: reset > clear > everything else;
//     in_valid coincident with clear is discarded.
//   acc width DATA_W+LOG2_N: cannot overflow; cnt width LOG2_N+1.
//   IDLE: on in_valid -> acc=in_data, run_min=run_max=in_data, cnt=1, go ACCUM.
//   ACCUM: on in_valid -> acc+=in_data, min/max compare (unsigned), cnt+=1.
//     Nth sample (cnt==N-1 & in_valid): at that same posedge load
//     out_mean=(acc+in_data)>>LOG2_N, out_min/out_max including that sample,
//     out_valid=1, go HOLD. Latency: out_valid visible the cycle after the Nth strobe.
//     No in_valid: hold all state.
//   HOLD: out_valid=1, out_mean/min/max stable until handshake.
//     Handshake (out_valid & out_ready): out_valid=0 next cycle; acc/cnt/min/max reinit.
//       If in_valid in the handshake cycle: sample taken as first of new batch
//       (acc=in_data, min=max=in_data, cnt=1, go ACCUM); else go IDLE.
//     in_valid without handshake: sample dropped, overrun=1 (sticky until reset/clear).
//   Outputs change only at posedge clk; no combinational path in->out.
//   Unused state encodings return to IDLE.
// TESTING
//   1. reset high 3 cycles -> out_valid=0, out_mean/min/max=0, overrun=0.
//   2. 16 strobes in_data=100 -> cycle after 16th: out_valid=1, mean=min=max=100.
//   3. strobes 0,1,..,15 -> mean=7 (120/16 truncated), min=0, max=15.
//   4. 16x in_data=60001 -> mean=60001, no overflow (acc=960016 < 2**20).
//   5. hold out_ready=0 10 cycles after result, 3 strobes in HOLD -> outputs stable,
//      overrun=1; raise out_ready with coincident strobe=50, then 15x50 -> mean=50,
//      overrun stays 1.
//   6. 5 strobes of 9000, clear 1 cycle, 16 strobes of 200 -> mean=min=max=200,
//      overrun=0.

Source files
------------

// File: rtl/coarse_interval_averager_if.sv
// Sample-in / batch-result-out signal bundle for the coarse interval averager.
// The averager uses the slave modport and the sample source/readout side uses master.
interface coarse_interval_averager_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_mean;
  logic [DATA_W-1:0] out_min;
  logic [DATA_W-1:0] out_max;
  logic              overrun;

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  out_valid, out_mean, out_min, out_max, overrun
  );

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output out_valid, out_mean, out_min, out_max, overrun
  );
endinterface

// File: rtl/coarse_interval_averager.sv
// Batches 2**LOG2_N coarse-counter intervals and reports the truncated mean, minimum and maximum.
// Samples that arrive while a result waits for readout are dropped and flagged by sticky overrun.
module coarse_interval_averager #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  coarse_interval_averager_if.slave bus
);
  localparam int ACC_W = DATA_W + LOG2_N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [LOG2_N:0] C_ONE  = (LOG2_N+1)'(1);
  localparam logic [LOG2_N:0] C_LAST = (LOG2_N+1)'((1 << LOG2_N) - 1);

  logic [1:0]        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [LOG2_N:0]   r_cnt;
  logic [DATA_W-1:0] r_run_min;
  logic [DATA_W-1:0] r_run_max;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_mean;
  logic [DATA_W-1:0] r_out_min;
  logic [DATA_W-1:0] r_out_max;
  logic              r_overrun;

  logic [ACC_W-1:0]  w_in_ext;
  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_min_next;
  logic [DATA_W-1:0] w_max_next;

  assign w_in_ext   = {{LOG2_N{1'b0}}, bus.in_data};
  assign w_sum      = r_acc + w_in_ext;
  assign w_min_next = (bus.in_data < r_run_min) ? bus.in_data : r_run_min;
  assign w_max_next = (bus.in_data > r_run_max) ? bus.in_data : r_run_max;

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_run_min   <= '1;
      r_run_max   <= '0;
      r_out_valid <= 1'b0;
      r_out_mean  <= '0;
      r_out_min   <= '0;
      r_out_max   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_acc     <= w_in_ext;
            r_run_min <= bus.in_data;
            r_run_max <= bus.in_data;
            r_cnt     <= C_ONE;
            r_state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            r_acc     <= w_sum;
            r_run_min <= w_min_next;
            r_run_max <= w_max_next;
            r_cnt     <= r_cnt + C_ONE;
            // The Nth sample is folded straight into the published result.
            if (r_cnt == C_LAST) begin
              r_out_mean  <= w_sum[ACC_W-1:LOG2_N];
              r_out_min   <= w_min_next;
              r_out_max   <= w_max_next;
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (bus.in_valid) begin
              r_acc     <= w_in_ext;
              r_run_min <= bus.in_data;
              r_run_max <= bus.in_data;
              r_cnt     <= C_ONE;
              r_state   <= S_ACCUM;
            end else begin
              r_acc     <= '0;
              r_run_min <= '1;
              r_run_max <= '0;
              r_cnt     <= '0;
              r_state   <= S_IDLE;
            end
          end else if (bus.in_valid) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_mean  = r_out_mean;
  assign bus.out_min   = r_out_min;
  assign bus.out_max   = r_out_max;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_coarse_interval_averager.sv
// Directed bench for coarse_interval_averager: batch statistics, latency, backpressure,
// overrun flagging and clear behaviour, each against hand-computed values.
module tb_coarse_interval_averager;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  coarse_interval_averager_if #(.DATA_W(16)) bus ();

  coarse_interval_averager #(
    .DATA_W(16),
    .LOG2_N(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns #1 after the capturing edge so outputs can be sampled.
  task automatic send(input logic [15:0] d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [15:0] mean,
                              input logic [15:0] mn, input logic [15:0] mx);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_mean"},  32'(bus.out_mean),  32'(mean));
    check_eq({tag, "_min"},   32'(bus.out_min),   32'(mn));
    check_eq({tag, "_max"},   32'(bus.out_max),   32'(mx));
    $display("result %s: mean=%0d min=%0d max=%0d overrun=%0d",
             tag, bus.out_mean, bus.out_min, bus.out_max, bus.overrun);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;

    // 1. reset state
    repeat (3) idle_cycle();
    check_eq("rst_valid",   32'(bus.out_valid), 32'd0);
    check_eq("rst_mean",    32'(bus.out_mean),  32'd0);
    check_eq("rst_min",     32'(bus.out_min),   32'd0);
    check_eq("rst_max",     32'(bus.out_max),   32'd0);
    check_eq("rst_overrun", 32'(bus.overrun),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();

    // 2. constant batch, with latency check on the 15th strobe
    for (int i = 0; i < 15; i++) send(16'd100);
    check_eq("t2_not_yet", 32'(bus.out_valid), 32'd0);
    send(16'd100);
    check_result("t2", 16'd100, 16'd100, 16'd100);
    idle_cycle();
    check_eq("t2_accepted", 32'(bus.out_valid), 32'd0);

    // 3. ramp 0..15: sum 120 -> mean 7
    for (int i = 0; i < 16; i++) send(16'(i));
    check_result("t3", 16'd7, 16'd0, 16'd15);
    idle_cycle();

    // 4. largest interval, accumulator must not wrap
    for (int i = 0; i < 16; i++) send(16'd60001);
    check_result("t4", 16'd60001, 16'd60001, 16'd60001);
    idle_cycle();

    // 5. backpressure with strobes while holding
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(16'd300 + 16'(i));
    check_result("t5a", 16'd307, 16'd300, 16'd315);
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 5 || c == 8) send(16'd7);
      else idle_cycle();
      check_eq("t5_hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("t5_hold_mean",  32'(bus.out_mean),  32'd307);
      check_eq("t5_hold_min",   32'(bus.out_min),   32'd300);
    end
    check_eq("t5_overrun", 32'(bus.overrun), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'd50;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("t5_handshake_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 14; i++) send(16'd50);
    check_eq("t5_not_yet", 32'(bus.out_valid), 32'd0);
    send(16'd50);
    check_result("t5b", 16'd50, 16'd50, 16'd50);
    check_eq("t5_overrun_sticky", 32'(bus.overrun), 32'd1);
    idle_cycle();

    // 6. partial batch, clear with a coincident (discarded) strobe, fresh batch
    for (int i = 0; i < 5; i++) send(16'd9000);
    @(negedge clk);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd9000;
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("t6_clr_valid",   32'(bus.out_valid), 32'd0);
    check_eq("t6_clr_overrun", 32'(bus.overrun),   32'd0);
    check_eq("t6_clr_mean",    32'(bus.out_mean),  32'd0);
    for (int i = 0; i < 15; i++) send(16'd200);
    check_eq("t6_not_yet", 32'(bus.out_valid), 32'd0);
    send(16'd200);
    check_result("t6", 16'd200, 16'd200, 16'd200);
    check_eq("t6_overrun", 32'(bus.overrun), 32'd0);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
